// File: rtl/perm_seq_pkg.sv
// Shared definitions for the permutation sequencer.
//   state_t : FSM state encoding (Fill, Kick, WaitLo, WaitHi, Drain; 3 bits)
//   clog2   : ceiling log2, used for counter widths
//   *_DEF   : default stream width, block size and watchdog limit
package perm_seq_pkg;

    localparam int W_DEF     = 32;
    localparam int WORDS_DEF = 4;
    localparam int TMO_DEF   = 64;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_KICK   = 3'd1,
        ST_WAITLO = 3'd2,
        ST_WAITHI = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/perm_word_counter.sv
// Word index counter shared by the fill and drain phases.
// Ports:
//   clk, rstN : clock, asynchronous active-low reset
//   clr       : synchronous clear (wins over en)
//   en        : advance by one
//   cnt       : current word index
//   tc        : high when cnt is the last index (WORDS-1)
module perm_word_counter
    import perm_seq_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int CW    = (clog2(WORDS) > 0) ? clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_r;

    // Index register; the owner clears it on the terminal transfer so it never wraps.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == CW'(WORDS - 1));

endmodule

// File: rtl/permutation_sequencer.sv
// Start/ready initiator for the permutation core: gathers WORDS stream words
// into a block, kicks the core, captures its result and streams it back out.
// Optional watchdog: define PERM_SEQ_TIMEOUT_EN to enable tmoErr.
// Ports:
//   clk, rstN                  : clock, asynchronous active-low reset
//   inValid/inReady/inData     : input word stream (word 0 first, bits [W-1:0])
//   outValid/outReady/outData  : output word stream, outLast on word WORDS-1
//   permStart/permReady        : core handshake (one-cycle start, ready = idle)
//   permIn/permOut             : core parallel block in / result out
//   busy                       : high in every state except Fill
//   tmoErr                     : sticky watchdog error (0 without the watchdog)
module permutation_sequencer
    import perm_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [W-1:0]       inData,
    output logic               outValid,
    input  logic               outReady,
    output logic [W-1:0]       outData,
    output logic               outLast,
    output logic               permStart,
    input  logic               permReady,
    output logic [W*WORDS-1:0] permIn,
    input  logic [W*WORDS-1:0] permOut,
    output logic               busy,
    output logic               tmoErr
);

    localparam int CW = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
    localparam int BW = W * WORDS;

    state_t          state_r, state_nx_s;
    logic [CW-1:0]   word_cnt_s;
    logic            word_tc_s;
    logic            in_fire_s, out_fire_s, cnt_en_s, cnt_clr_s;
    logic            capture_s, miss_s, retry_s;
    logic            lo_cnt_r, retry_r;
    logic            tmo_set_s, tmo_err_r;
    logic [BW-1:0]   perm_in_r, res_r;
    logic            in_ready_r, out_valid_r, perm_start_r, busy_r;

    perm_word_counter #(.WORDS(WORDS), .CW(CW)) u_cnt (
        .clk  (clk),
        .rstN (rstN),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .cnt  (word_cnt_s),
        .tc   (word_tc_s)
    );

    // in_ready_r / out_valid_r are exact decodes of Fill / Drain.
    assign in_fire_s  = inValid & in_ready_r;
    assign out_fire_s = out_valid_r & outReady;
    assign cnt_en_s   = in_fire_s | out_fire_s;
    assign cnt_clr_s  = cnt_en_s & word_tc_s;
    assign capture_s  = (state_r == ST_WAITHI) & permReady;
    // Core still idle on the second WaitLo cycle: it missed the start pulse.
    assign miss_s     = (state_r == ST_WAITLO) & permReady & lo_cnt_r;

`ifdef PERM_SEQ_TIMEOUT_EN
    localparam int TW = (clog2(TMO) > 0) ? clog2(TMO) : 1;
    logic [TW-1:0] wd_r;
    logic          waiting_s, wd_fire_s;

    assign waiting_s = (state_r == ST_WAITLO) | (state_r == ST_WAITHI);
    assign wd_fire_s = waiting_s & (wd_r == TW'(TMO - 1));
    // A repeated missed start is treated like a watchdog expiry.
    assign tmo_set_s = wd_fire_s | (miss_s & retry_r);

    // Watchdog: counts consecutive waiting cycles, restarts outside them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wd_r <= {TW{1'b0}};
        end else if (waiting_s & ~wd_fire_s) begin
            wd_r <= wd_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= {TW{1'b0}};
        end
    end
`else
    assign tmo_set_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        retry_s    = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (in_fire_s & word_tc_s) state_nx_s = ST_KICK;
                else                       state_nx_s = state_r;
            end
            ST_KICK: begin
                state_nx_s = ST_WAITLO;
            end
            ST_WAITLO: begin
                if (!permReady) begin
                    state_nx_s = ST_WAITHI;
                end else if (miss_s) begin
                    state_nx_s = ST_KICK;
                    retry_s    = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WAITHI: begin
                if (permReady) state_nx_s = ST_DRAIN;
                else           state_nx_s = state_r;
            end
            ST_DRAIN: begin
                if (out_fire_s & word_tc_s) state_nx_s = ST_FILL;
                else                        state_nx_s = state_r;
            end
            default: begin
                state_nx_s = ST_FILL;
            end
        endcase
        if (tmo_set_s) state_nx_s = ST_FILL;
        else           state_nx_s = state_nx_s;
    end

    // State, retry bookkeeping and registered handshake outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r      <= ST_FILL;
            lo_cnt_r     <= 1'b0;
            retry_r      <= 1'b0;
            tmo_err_r    <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            perm_start_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            // Second consecutive WaitLo cycle marker; a fresh Kick restarts it.
            lo_cnt_r     <= (state_r == ST_WAITLO) && (state_nx_s == ST_WAITLO);
            retry_r      <= (state_r == ST_FILL) ? 1'b0 : (retry_r | retry_s);
            tmo_err_r    <= tmo_err_r | tmo_set_s;
            in_ready_r   <= (state_nx_s == ST_FILL);
            busy_r       <= (state_nx_s != ST_FILL);
            perm_start_r <= (state_nx_s == ST_KICK);
            out_valid_r  <= (state_nx_s == ST_DRAIN);
        end
    end

    // Block input and result registers; permIn only changes while filling.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            perm_in_r <= {BW{1'b0}};
            res_r     <= {BW{1'b0}};
        end else begin
            if (in_fire_s) perm_in_r[int'(word_cnt_s)*W +: W] <= inData;
            else           perm_in_r <= perm_in_r;
            if (capture_s) res_r <= permOut;
            else           res_r <= res_r;
        end
    end

    // Output word select; held by the stable index while outReady is low.
    always_comb begin
        outData = {W{1'b0}};
        outData = res_r[int'(word_cnt_s)*W +: W];
    end

    assign inReady   = in_ready_r;
    assign outValid  = out_valid_r;
    assign outLast   = out_valid_r & word_tc_s;
    assign permStart = perm_start_r;
    assign permIn    = perm_in_r;
    assign busy      = busy_r;
    assign tmoErr    = tmo_err_r;

endmodule
